fx_match_pipe: RTL and testbench



---
 rtl/fx_pkg.sv | 32 +++
 rtl/fx_match_lane.sv | 102 ++++++++++
 rtl/fx_match_pipe.sv | 136 +++++++++++++
 tb/tb_fx_match_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// ---------------------------------------------------------------------------
// fx_pkg
// Shared definitions for the fixed-point format converter:
//   - rounding and overflow mode constants
//   - fx_qwidth : width of the quantized intermediate, including one guard MSB
//   - fx_max / fx_min : representable range of an OW-bit output word
// ---------------------------------------------------------------------------
package fx_pkg;

    localparam int FX_RND_TRUNC     = 0;
    localparam int FX_RND_HALF_UP   = 1;
    localparam int FX_RND_HALF_EVEN = 2;

    localparam int FX_OVF_WRAP      = 0;
    localparam int FX_OVF_SAT       = 1;

    // Input shifted by IF-OF, plus one guard bit so the rounding add cannot wrap.
    function automatic int fx_qwidth(input int iw, input int ifb, input int ofb);
        int w;
        w = iw - (ifb - ofb) + 1;
        return (w < 2) ? 2 : w;
    endfunction

    function automatic longint fx_max(input int ow, input int sgn);
        return (sgn != 0) ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
    endfunction

    function automatic longint fx_min(input int ow, input int sgn);
        return (sgn != 0) ? -(longint'(1) << (ow - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/fx_match_lane.sv
// ---------------------------------------------------------------------------
// fx_match_lane
// One lane of the converter: stage 1 quantizes the LSBs (truncate / half-up /
// half-even), stage 2 handles MSB overflow (wrap / saturate). Both registered.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : advance; 0 holds both stages
//   valid_i      : qualifier of the sample currently in stage 1 (gates ovf)
//   data_i       : Q(IW,IF) input word
//   data_o       : Q(OW,OF) output word (stage-2 register)
//   ovf_o        : overflow flag of data_o, already qualified by valid
// ---------------------------------------------------------------------------
module fx_match_lane
    import fx_pkg::*;
#(
    parameter int IW       = 12,
    parameter int IF       = 8,
    parameter int OW       = 14,
    parameter int OF       = 8,
    parameter int SIGNED   = 1,
    parameter int RND_MODE = 0,
    parameter int OVF_MODE = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          valid_i,
    input  logic [IW-1:0] data_i,
    output logic [OW-1:0] data_o,
    output logic          ovf_o
);

    localparam int SH = IF - OF;
    localparam int LS = (SH < 0) ? -SH : 0;
    localparam int RS = (SH > 0) ? SH : 0;
    localparam int QW = fx_qwidth(IW, IF, OF);
    // Working width: input, left shift, one guard bit and one spare for the rounding add.
    localparam int EW = IW + LS + 2;
    localparam int CW = ((QW > OW) ? QW : OW) + 1;
    localparam int BI = (RS > 0 && RS < EW) ? RS : 0;

    localparam logic [EW-1:0]        BIAS = (EW'(1) << RS) >> 1;
    localparam logic signed [CW-1:0] MAXV = CW'(fx_max(OW, SIGNED));
    localparam logic signed [CW-1:0] MINV = CW'(fx_min(OW, SIGNED));

    logic [EW-1:0]        ext;
    logic [EW-1:0]        sum;
    logic [EW-1:0]        shifted;
    logic [QW-1:0]        q_d, q_q;
    logic signed [CW-1:0] qx;
    logic [OW-1:0]        data_d, data_q;
    logic                 ovf_d, ovf_q;

    // Stage 1: quantize
    always_comb begin
        if (SIGNED != 0) ext = EW'($signed(data_i));
        else             ext = EW'(data_i);

        sum = ext;
        if (RS > 0) begin
            if (RND_MODE == FX_RND_HALF_UP)
                sum = ext + BIAS;
            else if (RND_MODE == FX_RND_HALF_EVEN)
                // Half minus one, plus the LSB that survives the shift: ties go to even.
                sum = ext + BIAS - EW'(1) + EW'(ext[BI]);
        end

        if (SH <= 0)          shifted = sum << LS;
        else if (SIGNED != 0) shifted = EW'($signed(sum) >>> RS);
        else                  shifted = sum >> RS;

        q_d = QW'(shifted);
    end

    // Stage 2: range check on the quantized value, compared in a common signed width
    always_comb begin
        if (SIGNED != 0) qx = CW'($signed(q_q));
        else             qx = CW'(q_q);

        ovf_d = (qx > MAXV) || (qx < MINV);

        if (ovf_d && OVF_MODE == FX_OVF_SAT)
            data_d = (qx > MAXV) ? OW'(MAXV) : OW'(MINV);
        else
            data_d = OW'(qx);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q    <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else if (en_i) begin
            q_q    <= q_d;
            data_q <= data_d;
            ovf_q  <= ovf_d & valid_i;
        end
    end

    assign data_o = data_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/fx_match_pipe.sv
// ---------------------------------------------------------------------------
// fx_match_pipe
// Pipelined fixed-point format converter, NCH lanes Q(IW,IF) -> Q(OW,OF).
// Two conversion stages per lane (fx_match_lane), then DELAY extra register
// stages. Latency is 2+DELAY enabled cycles; valid and ovf travel with data.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_en          : pipeline advance; 0 freezes every register
//   i_valid       : i_data qualifier
//   i_data        : packed lanes, lane k at [k*IW +: IW]
//   i_ovf_clr     : clears o_ovf_sticky (a simultaneous set wins)
//   o_valid       : o_data qualifier
//   o_data        : packed output lanes, lane k at [k*OW +: OW]
//   o_ovf         : per-lane overflow aligned with o_data, 0 when !o_valid
//   o_ovf_sticky  : per-lane latched overflow
// ---------------------------------------------------------------------------
module fx_match_pipe
    import fx_pkg::*;
#(
    parameter int NCH      = 1,
    parameter int IW       = 12,
    parameter int IF       = 8,
    parameter int OW       = 14,
    parameter int OF       = 8,
    parameter int SIGNED   = 1,
    parameter int RND_MODE = 0,
    parameter int OVF_MODE = 0,
    parameter int DELAY    = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [NCH*IW-1:0] i_data,
    input  logic              i_ovf_clr,
    output logic              o_valid,
    output logic [NCH*OW-1:0] o_data,
    output logic [NCH-1:0]    o_ovf,
    output logic [NCH-1:0]    o_ovf_sticky
);

    if (RND_MODE < 0 || RND_MODE > 2) begin : g_bad_rnd
        $error("fx_match_pipe: RND_MODE must be 0, 1 or 2");
    end
    if (OVF_MODE < 0 || OVF_MODE > 1) begin : g_bad_ovf
        $error("fx_match_pipe: OVF_MODE must be 0 or 1");
    end
    if (IW < 2 || OW < 2) begin : g_bad_width
        $error("fx_match_pipe: IW and OW must be at least 2");
    end
    if (DELAY < 0) begin : g_bad_delay
        $error("fx_match_pipe: DELAY must be non-negative");
    end

    logic              v1_q, v2_q;
    logic [NCH*OW-1:0] s2_data;
    logic [NCH-1:0]    s2_ovf;
    logic [NCH-1:0]    sticky_d, sticky_q;

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        fx_match_lane #(
            .IW       (IW),
            .IF       (IF),
            .OW       (OW),
            .OF       (OF),
            .SIGNED   (SIGNED),
            .RND_MODE (RND_MODE),
            .OVF_MODE (OVF_MODE)
        ) u_lane (
            .clk_i   (i_clk),
            .rst_i   (i_rst),
            .en_i    (i_en),
            .valid_i (v1_q),
            .data_i  (i_data[k*IW +: IW]),
            .data_o  (s2_data[k*OW +: OW]),
            .ovf_o   (s2_ovf[k])
        );
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else if (i_en) begin
            v1_q <= i_valid;
            v2_q <= v1_q;
        end
    end

    if (DELAY == 0) begin : g_nodly
        assign o_valid = v2_q;
        assign o_data  = s2_data;
        assign o_ovf   = s2_ovf;
    end else begin : g_dly
        logic              dv_q [DELAY];
        logic [NCH*OW-1:0] dd_q [DELAY];
        logic [NCH-1:0]    do_q [DELAY];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int unsigned i = 0; i < unsigned'(DELAY); i++) begin
                    dv_q[i] <= 1'b0;
                    dd_q[i] <= '0;
                    do_q[i] <= '0;
                end
            end else if (i_en) begin
                dv_q[0] <= v2_q;
                dd_q[0] <= s2_data;
                do_q[0] <= s2_ovf;
                for (int unsigned i = 1; i < unsigned'(DELAY); i++) begin
                    dv_q[i] <= dv_q[i-1];
                    dd_q[i] <= dd_q[i-1];
                    do_q[i] <= do_q[i-1];
                end
            end
        end

        assign o_valid = dv_q[DELAY-1];
        assign o_data  = dd_q[DELAY-1];
        assign o_ovf   = do_q[DELAY-1];
    end

    // Set has priority over clear so an overflow landing on a clear is not lost.
    always_comb begin
        sticky_d = sticky_q;
        if (i_en)
            sticky_d = (sticky_q & ~{NCH{i_ovf_clr}}) | (o_ovf & {NCH{o_valid}});
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) sticky_q <= '0;
        else       sticky_q <= sticky_d;
    end

    assign o_ovf_sticky = sticky_q;

endmodule

// File: tb/tb_fx_match_pipe.sv
// ---------------------------------------------------------------------------
// tb_fx_match_pipe
// Six single-lane converters Q(12,8)->Q(8,4) in different modes share one
// stimulus; a four-lane Q(12,8)->Q(14,8) converter runs alongside. Every
// cycle all outputs are compared against an arithmetic reference model fed
// through a history of accepted samples.
// ---------------------------------------------------------------------------
module tb_fx_match_pipe;

    localparam int NI = 6;
    localparam int SG [NI] = '{1, 1, 1, 1, 1, 0};
    localparam int RM [NI] = '{0, 1, 2, 0, 1, 2};
    localparam int OM [NI] = '{1, 1, 1, 0, 0, 1};
    localparam int DL [NI] = '{1, 1, 1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst, en, vld, clr;
    logic [11:0] din;
    logic [47:0] dw;

    logic [7:0]  od [NI];
    logic        ov [NI];
    logic        oo [NI];
    logic        os [NI];

    logic        wv;
    logic [55:0] wd;
    logic [3:0]  wo, ws;

    int checks = 0;
    int errors = 0;

    // Reference state: last three accepted samples (index 0 = newest) and sticky flags
    logic        hv [3];
    logic [11:0] hd [3];
    logic [47:0] hw [3];
    logic        sm [NI];
    logic [3:0]  swm;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        fx_match_pipe #(
            .NCH      (1),
            .IW       (12),
            .IF       (8),
            .OW       (8),
            .OF       (4),
            .SIGNED   (SG[g]),
            .RND_MODE (RM[g]),
            .OVF_MODE (OM[g]),
            .DELAY    (DL[g])
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_en         (en),
            .i_valid      (vld),
            .i_data       (din),
            .i_ovf_clr    (clr),
            .o_valid      (ov[g]),
            .o_data       (od[g]),
            .o_ovf        (oo[g]),
            .o_ovf_sticky (os[g])
        );
    end

    fx_match_pipe #(
        .NCH      (4),
        .IW       (12),
        .IF       (8),
        .OW       (14),
        .OF       (8),
        .SIGNED   (1),
        .RND_MODE (1),
        .OVF_MODE (1),
        .DELAY    (1)
    ) u_wide (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_valid      (vld),
        .i_data       (dw),
        .i_ovf_clr    (clr),
        .o_valid      (wv),
        .o_data       (wd),
        .o_ovf        (wo),
        .o_ovf_sticky (ws)
    );

    // Real-valued conversion with floor division, rounding and range rules.
    function automatic void conv(input logic [11:0] raw, input int sgn, input int ifb,
                                 input int ofb, input int ow, input int rnd, input int ovm,
                                 output logic [15:0] dout, output logic ovf);
        longint x, d, q, r, mx, mn;
        int sh;
        x = longint'(raw);
        if (sgn != 0 && raw[11]) x = x - 4096;
        sh = ifb - ofb;
        if (sh <= 0) begin
            q = x * (longint'(1) << (-sh));
        end else begin
            d = longint'(1) << sh;
            q = x / d;
            if ((x % d) != 0 && x < 0) q = q - 1;
            r = x - q * d;
            if (rnd == 1 && 2 * r >= d) q = q + 1;
            else if (rnd == 2 && (2 * r > d || (2 * r == d && (q % 2) != 0))) q = q + 1;
        end
        mx = (sgn != 0) ? (longint'(1) << (ow - 1)) - 1 : (longint'(1) << ow) - 1;
        mn = (sgn != 0) ? -(longint'(1) << (ow - 1)) : 0;
        ovf = (q > mx) || (q < mn);
        if (ovf && ovm == 1) q = (q > mx) ? mx : mn;
        dout = 16'(q & ((longint'(1) << ow) - 1));
    endfunction

    task automatic chk(input string tag, input int idx, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %h expected %h", tag, idx, got, exp);
        end
    endtask

    function automatic logic exp_ovf(input int g);
        logic [15:0] e;
        logic        eo;
        int          l;
        l = DL[g] + 2;
        conv(hd[l-1], SG[g], 8, 4, 8, RM[g], OM[g], e, eo);
        return eo & hv[l-1];
    endfunction

    function automatic logic [3:0] exp_wovf();
        logic [15:0] e;
        logic        eo;
        logic [3:0]  r;
        for (int k = 0; k < 4; k++) begin
            conv(hw[2][k*12 +: 12], 1, 8, 8, 14, 1, 1, e, eo);
            r[k] = eo & hv[2];
        end
        return r;
    endfunction

    task automatic check_all();
        logic [15:0] e;
        logic        eo;
        logic [55:0] ew;
        int          l;
        for (int g = 0; g < NI; g++) begin
            l = DL[g] + 2;
            conv(hd[l-1], SG[g], 8, 4, 8, RM[g], OM[g], e, eo);
            chk("valid", g, 64'(ov[g]), 64'(hv[l-1]));
            chk("data", g, 64'(od[g]), 64'(e[7:0]));
            chk("ovf", g, 64'(oo[g]), 64'(eo & hv[l-1]));
            chk("sticky", g, 64'(os[g]), 64'(sm[g]));
        end
        for (int k = 0; k < 4; k++) begin
            conv(hw[2][k*12 +: 12], 1, 8, 8, 14, 1, 1, e, eo);
            ew[k*14 +: 14] = e[13:0];
        end
        chk("wide_valid", 0, 64'(wv), 64'(hv[2]));
        chk("wide_data", 0, 64'(wd), 64'(ew));
        chk("wide_ovf", 0, 64'(wo), 64'(exp_wovf()));
        chk("wide_sticky", 0, 64'(ws), 64'(swm));
    endtask

    task automatic step(input logic v, input logic [11:0] d, input logic [47:0] w,
                        input logic e, input logic c, input logic r);
        vld = v; din = d; dw = w; en = e; clr = c; rst = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                hv[i] = 1'b0; hd[i] = '0; hw[i] = '0;
            end
            for (int g = 0; g < NI; g++) sm[g] = 1'b0;
            swm = '0;
        end else if (e) begin
            for (int g = 0; g < NI; g++) sm[g] = (sm[g] & ~c) | exp_ovf(g);
            swm = (swm & ~{4{c}}) | exp_wovf();
            for (int i = 2; i > 0; i--) begin
                hv[i] = hv[i-1]; hd[i] = hd[i-1]; hw[i] = hw[i-1];
            end
            hv[0] = v; hd[0] = d; hw[0] = w;
        end
        #1;
        check_all();
    endtask

    function automatic logic [11:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return 12'h7F8 | 12'($urandom_range(0, 7));
            1:       return 12'hFF8 | 12'($urandom_range(0, 7));
            default: return 12'($urandom);
        endcase
    endfunction

    logic [11:0] dsamp [4] = '{12'h018, 12'h028, 12'hFE8, 12'h7FF};
    logic [7:0]  dexp [5][4] = '{
        '{8'h01, 8'h02, 8'hFE, 8'h7F},
        '{8'h02, 8'h03, 8'hFF, 8'h7F},
        '{8'h02, 8'h02, 8'hFE, 8'h7F},
        '{8'h01, 8'h02, 8'hFE, 8'h7F},
        '{8'h02, 8'h03, 8'hFF, 8'h80}
    };
    logic [3:0]  dovf [5] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    logic [47:0] wsamp = {12'hFFF, 12'h001, 12'h7FF, 12'h800};

    initial begin
        for (int i = 0; i < 3; i++) begin
            hv[i] = 1'b0; hd[i] = '0; hw[i] = '0;
        end
        for (int g = 0; g < NI; g++) sm[g] = 1'b0;
        swm = '0;

        // Reset state
        step(0, 12'h000, '0, 1, 0, 1);
        step(0, 12'h000, '0, 1, 0, 1);
        chk("rst_valid", 0, 64'(ov[0]), 64'(0));
        chk("rst_data", 0, 64'(od[0]), 64'(0));

        // Rounding / overflow sweep on back-to-back samples, plus the wide lanes
        for (int i = 0; i < 6; i++) begin
            step(i < 4, (i < 4) ? dsamp[i] : 12'h000, (i == 0) ? wsamp : 48'h0, 1, 0, 0);
            if (i >= 2) begin
                for (int g = 0; g < 5; g++) begin
                    chk("sweep_data", g, 64'(od[g]), 64'(dexp[g][i-2]));
                    chk("sweep_ovf", g, 64'(oo[g]), 64'(dovf[g][i-2]));
                end
            end
            if (i == 2) begin
                chk("wide_const", 0, 64'(wd), 64'({14'h3FFF, 14'h0001, 14'h07FF, 14'h3800}));
                chk("wide_const_ovf", 0, 64'(wo), 64'(0));
            end
        end

        // Sticky hold, clear, and clear coinciding with a new overflow
        for (int i = 0; i < 10; i++) step(0, 12'h000, '0, 1, 0, 0);
        chk("sticky_hold", 1, 64'(os[1]), 64'(1));
        chk("sticky_hold", 0, 64'(os[0]), 64'(0));
        step(0, 12'h000, '0, 1, 1, 0);
        chk("sticky_clr", 1, 64'(os[1]), 64'(0));
        step(1, 12'h7FF, '0, 1, 0, 0);
        step(0, 12'h000, '0, 1, 0, 0);
        step(0, 12'h000, '0, 1, 0, 0);
        step(0, 12'h000, '0, 1, 1, 0);
        chk("sticky_setwins", 1, 64'(os[1]), 64'(1));
        chk("sticky_setwins", 4, 64'(os[4]), 64'(1));

        // Stall mid-stream
        for (int i = 0; i < 8; i++)
            step(1, rand_word(), {16'($urandom), $urandom}, !(i == 3 || i == 4), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 12'h000, '0, 1, 0, 0);

        // Reset with samples in flight
        for (int i = 0; i < 3; i++) step(1, rand_word(), {16'($urandom), $urandom}, 1, 0, 0);
        step(1, 12'h123, '0, 1, 0, 1);
        chk("midrst_valid", 0, 64'(ov[0]), 64'(0));
        step(1, 12'h028, '0, 1, 0, 0);
        step(0, 12'h000, '0, 1, 0, 0);
        chk("midrst_early", 0, 64'(ov[0]), 64'(0));
        step(0, 12'h000, '0, 1, 0, 0);
        chk("midrst_new", 0, 64'(ov[0]), 64'(1));
        chk("midrst_data", 1, 64'(od[1]), 64'(8'h03));

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), rand_word(), {16'($urandom), $urandom},
                 $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 49) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
